// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, async-read instruction memory address, IF/ID register.
// Optional performance counters are built when FETCH_PERF_COUNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;

  // Redirect targets are always word aligned; the low bits are dropped.
  logic [1:0] unused_br_lsb;
  assign unused_br_lsb = branch_address[1:0];

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if (branch_taken) begin
      pc_d       = {branch_address[31:2], 2'b00};
      if_pc_d    = 32'd0;
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end else if (!freeze) begin
      pc_d       = pc_plus4;
      if_pc_d    = pc_plus4;
      if_instr_d = mem_instruction;
      if_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= {RESET_PC[31:2], 2'b00};
      if_pc_q    <= 32'd0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign mem_address       = pc_q;
  assign if_id_pc          = if_pc_q;
  assign if_id_instruction = if_instr_q;
  assign if_id_valid       = if_valid_q;

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!branch_taken && !freeze) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (!branch_taken && freeze)  stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic
// compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam logic [31:0] Nop   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = 32'd0;
  logic [31:0] mem_address;
  logic [31:0] mem_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [31:0] key = 32'd0;
  assign mem_instruction = mem_address ^ key;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (RstPc),
    .NOP_INSTR (Nop)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .freeze            (freeze),
    .branch_taken      (branch_taken),
    .branch_address    (branch_address),
    .mem_address       (mem_address),
    .mem_instruction   (mem_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .fetch_count       (fetch_count),
    .stall_count       (stall_count)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_ifinstr, m_fetch, m_stall;
  logic        m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mem_address", mem_address, m_pc);
    chk("if_id_pc", if_id_pc, m_ifpc);
    chk("if_id_instruction", if_id_instruction, m_ifinstr);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_COUNT_EN
    chk("fetch_count", fetch_count, m_fetch);
    chk("stall_count", stall_count, m_stall);
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, check 1 time unit later.
  task automatic step(input logic r, input logic b, input logic f, input logic [31:0] a);
    logic [31:0] fetched;
    @(negedge clk);
    rst = r; branch_taken = b; freeze = f; branch_address = a;
    @(posedge clk);
    fetched = m_pc ^ key;
    if (r) begin
      m_pc = RstPc; m_ifpc = 0; m_ifinstr = Nop; m_valid = 0; m_fetch = 0; m_stall = 0;
    end else if (b) begin
      m_pc = a & ~32'd3; m_ifpc = 0; m_ifinstr = Nop; m_valid = 0;
    end else if (f) begin
      m_stall = m_stall + 1;
    end else begin
      m_pc = m_pc + 4; m_ifpc = m_pc; m_ifinstr = fetched; m_valid = 1;
      m_fetch = m_fetch + 1;
    end
    #1;
    check_all();
  endtask

  initial begin
    m_pc = 0; m_ifpc = 0; m_ifinstr = 0; m_valid = 0; m_fetch = 0; m_stall = 0;

    // Reset, then straight-line fetch with word = address
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_pc", mem_address, 32'h0);
    step(0, 0, 0, 0);
    chk("seq_ifid_pc0", if_id_pc, 32'h4);
    step(0, 0, 0, 0);
    chk("seq_ifid_instr1", if_id_instruction, 32'h4);

    // Freeze three cycles at pc = 8
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      chk("freeze_hold_pc", mem_address, 32'h8);
      chk("freeze_hold_ifid", if_id_pc, 32'h8);
    end
    step(0, 0, 0, 0);
    chk("after_freeze_ifid", if_id_instruction, 32'h8);

    // Branch under freeze at pc = 12, misaligned target
    step(0, 1, 1, 32'h0000_0103);
    chk("branch_pc", mem_address, 32'h100);
    chk("branch_bubble", {31'd0, if_id_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("branch_target_ifid_pc", if_id_pc, 32'h104);
    chk("branch_target_ifid_instr", if_id_instruction, 32'h100);

    // Wrap-around
    step(0, 1, 0, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_pc", mem_address, 32'h0);
    chk("wrap_ifid_pc", if_id_pc, 32'h0);

    // Multi-cycle branch reloads target each cycle
    step(0, 1, 0, 32'h0000_2000);
    step(0, 1, 0, 32'h0000_2000);
    chk("branch_hold_pc", mem_address, 32'h2000);

    // Reset overrides branch and freeze
    step(0, 0, 0, 0);
    step(1, 1, 1, 32'h0000_4440);
    chk("midrun_rst_pc", mem_address, RstPc);
    chk("midrun_rst_valid", {31'd0, if_id_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic r, b, f;
      if ($urandom_range(0, 49) == 0) key = $urandom;
      r = ($urandom_range(0, 99) < 2);
      b = ($urandom_range(0, 99) < 12);
      f = ($urandom_range(0, 99) < 25);
      step(r, b, f, ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
